// File: rtl/wash_pkg.sv
// ---------------------------------------------------------------------------
// wash_pkg
// Shared definitions for the wash phase sequencer:
//   - 3-bit phase/state codes (IDLE=0 .. DONE=5) and the matching enum
//   - default duration / remaining-time width TW_DEFAULT
//   - next_phase(): picks the next phase with a nonzero duration, so that
//     zero-length phases are skipped without spending a clock in them
// ---------------------------------------------------------------------------
package wash_pkg;

    localparam int TW_DEFAULT = 8;

    localparam logic [2:0] PH_IDLE      = 3'd0;
    localparam logic [2:0] PH_SPRAY     = 3'd1;
    localparam logic [2:0] PH_DRY       = 3'd2;
    localparam logic [2:0] PH_DISCHARGE = 3'd3;
    localparam logic [2:0] PH_PAUSED    = 3'd4;
    localparam logic [2:0] PH_DONE      = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = PH_IDLE,
        ST_SPRAY     = PH_SPRAY,
        ST_DRY       = PH_DRY,
        ST_DISCHARGE = PH_DISCHARGE,
        ST_PAUSED    = PH_PAUSED,
        ST_DONE      = PH_DONE
    } phase_e;

    // Returns the first phase after 'from' (in SPRAY, DRY, DISCHARGE order)
    // whose duration is nonzero, or DONE when none remains.
    function automatic phase_e next_phase(input phase_e from,
                                          input logic   sprayNz,
                                          input logic   dryNz,
                                          input logic   disNz);
        next_phase = ST_DONE;
        if ((from == ST_IDLE) && sprayNz) begin
            next_phase = ST_SPRAY;
        end else if ((from inside {ST_IDLE, ST_SPRAY}) && dryNz) begin
            next_phase = ST_DRY;
        end else if ((from inside {ST_IDLE, ST_SPRAY, ST_DRY}) && disNz) begin
            next_phase = ST_DISCHARGE;
        end
    endfunction

endpackage

// File: rtl/wash_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// wash_phase_sequencer_if
// Groups the controller-facing signals of the wash phase sequencer.
//   Controller -> sequencer : ce, start, abort, pause, lid_open,
//                             spray_time, dry_time, dis_time
//   Sequencer -> controller : spray_on, dry_on, dis_on, busy, done, wd_err,
//                             phase, remaining
// Modports: master = controller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface wash_phase_sequencer_if
    import wash_pkg::*;
#(
    parameter int TW = TW_DEFAULT
);

    logic          ce;
    logic          start;
    logic          abort;
    logic          pause;
    logic          lid_open;
    logic [TW-1:0] spray_time;
    logic [TW-1:0] dry_time;
    logic [TW-1:0] dis_time;

    logic          spray_on;
    logic          dry_on;
    logic          dis_on;
    logic          busy;
    logic          done;
    logic          wd_err;
    logic [2:0]    phase;
    logic [TW-1:0] remaining;

    modport master (
        output ce, start, abort, pause, lid_open,
        output spray_time, dry_time, dis_time,
        input  spray_on, dry_on, dis_on, busy, done, wd_err, phase, remaining
    );

    modport slave (
        input  ce, start, abort, pause, lid_open,
        input  spray_time, dry_time, dis_time,
        output spray_on, dry_on, dis_on, busy, done, wd_err, phase, remaining
    );

endinterface

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// TW-bit down-counter holding the ticks left in the current wash phase.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val (takes priority over dec)
//   load_val     : value to load
//   dec          : decrement by one (ce gated with "phase active")
//   count        : current counter value
//   expire       : last tick of the phase (count==1 while dec)
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic [TW-1:0] count,
    output logic          expire
);

    logic [TW-1:0] countQ;

    // A load on the same edge as a decrement wins, so the FSM can chain
    // straight into the next phase on the expiring tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            countQ <= '0;
        end else if (load) begin
            countQ <= load_val;
        end else if (dec) begin
            countQ <= countQ - 1'b1;
        end
    end

    assign count  = countQ;
    assign expire = dec && (countQ == TW'(1));

endmodule

// File: rtl/wash_phase_sequencer.sv
// ---------------------------------------------------------------------------
// wash_phase_sequencer
// Runs one wash programme through SPRAY -> DRY -> DISCHARGE, each phase
// lasting its latched duration in ce ticks. Supports pause/lid-open freeze
// (SPRAY and DRY only), abort-with-drain and reports phase/remaining time.
// Ports:
//   clk     : 1 MHz system clock
//   reset_n : asynchronous active-low reset
//   bus     : wash_phase_sequencer_if.slave (control inputs, enables,
//             status, phase code and remaining ticks)
// Configuration macro:
//   WASH_SEQ_WATCHDOG_EN : builds a ce-tick watchdog of WD_TICKS that forces
//                          IDLE and sets the sticky wd_err; otherwise wd_err
//                          is tied low.
// ---------------------------------------------------------------------------
module wash_phase_sequencer
    import wash_pkg::*;
#(
    parameter int TW       = TW_DEFAULT,
    parameter int WD_TICKS = 1023
) (
    input  logic                   clk,
    input  logic                   reset_n,
    wash_phase_sequencer_if.slave  bus
);

    phase_e        stateQ, stateD;
    phase_e        resumeQ, resumeD;
    phase_e        nextPh;
    logic [TW-1:0] sprayDurQ, dryDurQ, disDurQ;
    logic          latchDur;
    logic          sprayOnQ, dryOnQ, disOnQ, busyQ, doneQ;
    logic          holdReq;
    logic          timerLoad, timerDec, timerExpire;
    logic [TW-1:0] timerLoadVal, timerCount;
    logic          wdTrip;
    logic          wdErrQ;

    if (WD_TICKS < 2) begin : gWdTicksCheck
        $error("WD_TICKS must be at least 2");
    end

    function automatic logic [TW-1:0] durFor(input phase_e ph,
                                             input logic [TW-1:0] sp,
                                             input logic [TW-1:0] dr,
                                             input logic [TW-1:0] ds);
        case (ph)
            ST_SPRAY:     durFor = sp;
            ST_DRY:       durFor = dr;
            ST_DISCHARGE: durFor = ds;
            default:      durFor = '0;
        endcase
    endfunction

    assign holdReq = bus.pause || bus.lid_open;

    // Ticks only count in a running phase; abort and pause outrank expiry, so
    // they also block the decrement in SPRAY/DRY. DISCHARGE ignores pause.
    assign timerDec = bus.ce &&
                      (((stateQ inside {ST_SPRAY, ST_DRY}) && !bus.abort && !holdReq) ||
                       (stateQ == ST_DISCHARGE));

    phase_timer #(.TW(TW)) uTimer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timerLoad),
        .load_val (timerLoadVal),
        .dec      (timerDec),
        .count    (timerCount),
        .expire   (timerExpire)
    );

`ifdef WASH_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_TICKS + 1);

    logic [WD_W-1:0] wdCountQ;
    logic            wdCounting;

    // Counter freezes in PAUSED and clears whenever the sequencer is idle.
    assign wdCounting = stateQ inside {ST_SPRAY, ST_DRY, ST_DISCHARGE, ST_DONE};
    assign wdTrip     = bus.ce && wdCounting && (wdCountQ == WD_W'(WD_TICKS - 1));

    // Watchdog tick counter and sticky error flag (cleared only by reset).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdCountQ <= '0;
            wdErrQ   <= 1'b0;
        end else begin
            if (stateQ == ST_IDLE) begin
                wdCountQ <= '0;
            end else if (bus.ce && wdCounting) begin
                wdCountQ <= wdCountQ + 1'b1;
            end
            if (wdTrip) begin
                wdErrQ <= 1'b1;
            end
        end
    end
`else
    assign wdTrip = 1'b0;
    assign wdErrQ = 1'b0;
`endif

    // Next-state decision. Every transition into a timed phase loads the
    // timer on the same edge; DONE and IDLE park the timer at zero.
    always_comb begin
        stateD       = stateQ;
        resumeD      = resumeQ;
        nextPh       = ST_DONE;
        latchDur     = 1'b0;
        timerLoad    = 1'b0;
        timerLoadVal = '0;

        case (stateQ)
            ST_IDLE: begin
                if (bus.start && !wdErrQ) begin
                    latchDur     = 1'b1;
                    nextPh       = next_phase(ST_IDLE, bus.spray_time != '0,
                                              bus.dry_time != '0, bus.dis_time != '0);
                    stateD       = nextPh;
                    timerLoad    = 1'b1;
                    timerLoadVal = durFor(nextPh, bus.spray_time, bus.dry_time, bus.dis_time);
                end
            end
            ST_SPRAY, ST_DRY: begin
                if (bus.abort) begin
                    timerLoad    = 1'b1;
                    timerLoadVal = disDurQ;
                    stateD       = (disDurQ != '0) ? ST_DISCHARGE : ST_DONE;
                end else if (holdReq) begin
                    resumeD = stateQ;
                    stateD  = ST_PAUSED;
                end else if (timerExpire) begin
                    nextPh       = next_phase(stateQ, sprayDurQ != '0,
                                              dryDurQ != '0, disDurQ != '0);
                    stateD       = nextPh;
                    timerLoad    = 1'b1;
                    timerLoadVal = durFor(nextPh, sprayDurQ, dryDurQ, disDurQ);
                end
            end
            ST_PAUSED: begin
                if (bus.abort) begin
                    timerLoad    = 1'b1;
                    timerLoadVal = disDurQ;
                    stateD       = (disDurQ != '0) ? ST_DISCHARGE : ST_DONE;
                end else if (!holdReq) begin
                    stateD = resumeQ;
                end
            end
            ST_DISCHARGE: begin
                if (timerExpire) begin
                    stateD    = ST_DONE;
                    timerLoad = 1'b1;
                end
            end
            ST_DONE: begin
                stateD = ST_IDLE;
            end
            default: begin
                stateD    = ST_IDLE;
                timerLoad = 1'b1;
            end
        endcase

        if (wdTrip) begin
            stateD       = ST_IDLE;
            latchDur     = 1'b0;
            timerLoad    = 1'b1;
            timerLoadVal = '0;
        end
    end

    // State, latched durations and registered outputs. Enables are derived
    // from the next state so they switch on the same edge as the phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= ST_IDLE;
            resumeQ   <= ST_IDLE;
            sprayDurQ <= '0;
            dryDurQ   <= '0;
            disDurQ   <= '0;
            sprayOnQ  <= 1'b0;
            dryOnQ    <= 1'b0;
            disOnQ    <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            stateQ  <= stateD;
            resumeQ <= resumeD;
            if (latchDur) begin
                sprayDurQ <= bus.spray_time;
                dryDurQ   <= bus.dry_time;
                disDurQ   <= bus.dis_time;
            end
            sprayOnQ <= (stateD == ST_SPRAY);
            dryOnQ   <= (stateD == ST_DRY);
            disOnQ   <= (stateD == ST_DISCHARGE);
            busyQ    <= (stateD != ST_IDLE);
            doneQ    <= (stateD == ST_DONE);
        end
    end

    assign bus.spray_on  = sprayOnQ;
    assign bus.dry_on    = dryOnQ;
    assign bus.dis_on    = disOnQ;
    assign bus.busy      = busyQ;
    assign bus.done      = doneQ;
    assign bus.wd_err    = wdErrQ;
    assign bus.phase     = stateQ;
    assign bus.remaining = timerCount;

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wash_phase_sequencer
// Directed bench for wash_phase_sequencer: normal programme, zero-phase skip,
// lid-open pause, abort with and without drain, asynchronous reset and (when
// WASH_SEQ_WATCHDOG_EN is defined) the watchdog trip.
// ---------------------------------------------------------------------------
module tb_wash_phase_sequencer;

    localparam int TW = 8;

    logic clk;
    logic reset_n;
    logic lidLevel;
    int   checks;
    int   failures;

    int   s1Ph  [9] = '{1, 1, 2, 2, 3, 3, 3, 3, 5};
    int   s1Rem [9] = '{2, 1, 2, 1, 4, 3, 2, 1, 0};

    wash_phase_sequencer_if #(.TW(TW)) bus ();

    wash_phase_sequencer #(.TW(TW), .WD_TICKS(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drive one clock of inputs, return 1 time unit after the active edge.
    task automatic applyStimulus(input logic ceV, input logic startV,
                                 input logic abortV, input logic pauseV,
                                 input logic lidV);
        bus.ce       = ceV;
        bus.start    = startV;
        bus.abort    = abortV;
        bus.pause    = pauseV;
        bus.lid_open = lidV;
        @(posedge clk);
        #1;
    endtask

    task automatic setDurations(input int sp, input int dr, input int ds);
        bus.spray_time = TW'(sp);
        bus.dry_time   = TW'(dr);
        bus.dis_time   = TW'(ds);
    endtask

    task automatic checkPhase(input string tag, input int ph, input int rem);
        checkOutput({tag, ".phase"}, 32'(bus.phase), 32'(ph));
        checkOutput({tag, ".remaining"}, 32'(bus.remaining), 32'(rem));
        checkOutput({tag, ".spray_on"}, 32'(bus.spray_on), 32'(ph == 1));
        checkOutput({tag, ".dry_on"}, 32'(bus.dry_on), 32'(ph == 2));
        checkOutput({tag, ".dis_on"}, 32'(bus.dis_on), 32'(ph == 3));
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(ph != 0));
        checkOutput({tag, ".done"}, 32'(bus.done), 32'(ph == 5));
    endtask

    // One ce tick followed by one idle clock; DONE must fall to IDLE on the
    // idle clock, any other phase must hold.
    task automatic checkTick(input string tag, input int ph, input int rem);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, lidLevel);
        checkPhase(tag, ph, rem);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, lidLevel);
        if (ph == 5) checkPhase({tag, "_idle"}, 0, 0);
        else         checkPhase({tag, "_gap"}, ph, rem);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        lidLevel = 1'b0;
        reset_n  = 1'b0;
        bus.ce = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.pause = 1'b0; bus.lid_open = 1'b0;
        setDurations(0, 0, 0);
        #12;
        checkPhase("reset", 0, 0);
        checkOutput("reset.wd_err", 32'(bus.wd_err), 32'd0);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Durations 3/2/4 back to back.
        setDurations(3, 2, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("s1_start", 1, 3);
        for (int k = 0; k < 9; k++) checkTick($sformatf("s1_t%0d", k + 1), s1Ph[k], s1Rem[k]);

        // Durations 0/5/0: SPRAY skipped on the start edge.
        setDurations(0, 5, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("s2_start", 2, 5);
        for (int r = 4; r >= 1; r--) checkTick($sformatf("s2_r%0d", r), 2, r);
        checkTick("s2_end", 5, 0);

`ifndef WASH_SEQ_WATCHDOG_EN
        // Durations 6/6/6 with lid open during SPRAY; DISCHARGE ignores lid.
        setDurations(6, 6, 6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("s3_start", 1, 6);
        checkTick("s3_t1", 1, 5);
        checkTick("s3_t2", 1, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkPhase("s3_pause", 4, 4);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            checkPhase($sformatf("s3_held%0d", k), 4, 4);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkPhase("s3_resume", 1, 4);
        for (int r = 3; r >= 1; r--) checkTick($sformatf("s3_sp%0d", r), 1, r);
        checkTick("s3_to_dry", 2, 6);
        for (int r = 5; r >= 1; r--) checkTick($sformatf("s3_dr%0d", r), 2, r);
        checkTick("s3_to_dis", 3, 6);
        lidLevel = 1'b1;
        for (int r = 5; r >= 1; r--) checkTick($sformatf("s3_ds%0d", r), 3, r);
        checkTick("s3_end", 5, 0);
        lidLevel = 1'b0;
`endif

        // Abort in DRY with remaining 3, dis_time 2.
        setDurations(1, 5, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("s4_start", 1, 1);
        checkTick("s4_t1", 2, 5);
        checkTick("s4_t2", 2, 4);
        checkTick("s4_t3", 2, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkPhase("s4_abort", 3, 2);
        checkTick("s4_d1", 3, 1);
        checkTick("s4_end", 5, 0);

        // Abort in DRY with dis_time 0 goes straight to DONE.
        setDurations(1, 5, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("s5_start", 1, 1);
        checkTick("s5_t1", 2, 5);
        checkTick("s5_t2", 2, 4);
        checkTick("s5_t3", 2, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkPhase("s5_abort", 5, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkPhase("s5_idle", 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkPhase("s5_abort_idle", 0, 0);

        // Asynchronous reset in the middle of DISCHARGE.
        setDurations(1, 1, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("s6_start", 1, 1);
        checkTick("s6_t1", 2, 1);
        checkTick("s6_t2", 3, 5);
        checkTick("s6_t3", 3, 4);
        #2;
        reset_n = 1'b0;
        #1;
        checkPhase("s6_async_rst", 0, 0);
        #1;
        reset_n = 1'b1;
        setDurations(2, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("s6_restart", 1, 2);
        checkTick("s6_r1", 1, 1);
        checkTick("s6_rend", 5, 0);

`ifdef WASH_SEQ_WATCHDOG_EN
        // Watchdog of 10 ticks against an 8/8/8 programme.
        setDurations(8, 8, 8);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("wd_start", 1, 8);
        for (int r = 7; r >= 1; r--) checkTick($sformatf("wd_sp%0d", r), 1, r);
        checkTick("wd_t8", 2, 8);
        checkTick("wd_t9", 2, 7);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkPhase("wd_trip", 0, 0);
        checkOutput("wd_trip.wd_err", 32'(bus.wd_err), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkPhase("wd_start_ignored", 0, 0);
        checkOutput("wd_sticky.wd_err", 32'(bus.wd_err), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        checkOutput("nowd.wd_err", 32'(bus.wd_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
